// File: rtl/ccd_seq_pkg.sv
// rtl/ccd_seq_pkg.sv - opcodes, state enums and header constants for the CCD frame sequencer
package ccd_seq_pkg;

   localparam logic [7:0] CMD_SINGLE = 8'h01;
   localparam logic [7:0] CMD_CONT   = 8'h02;
   localparam logic [7:0] CMD_STOP   = 8'h03;

   localparam logic [7:0] HDR0_DEF   = 8'hA5;
   localparam logic [7:0] HDR1_DEF   = 8'h5A;

   // One buffered sample: {overflow, adc[11:0]}
   localparam int SAMPLE_W = 13;

   typedef enum logic [2:0] {
      FE_IDLE,
      FE_ARM,
      FE_SKIP,
      FE_CAPTURE,
      FE_WAIT_TX
   } fe_state_t;

   typedef enum logic [1:0] {
      BE_IDLE,
      BE_HDR,
      BE_PAYLOAD,
      BE_TRL
   } be_state_t;

endpackage

// File: rtl/sample_fifo.sv
// rtl/sample_fifo.sv - synchronous first-word-fall-through sample buffer
module sample_fifo #(
   parameter int WIDTH = 13,
   parameter int DEPTH = 64
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             wr_en,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             rd_en,
   output logic [WIDTH-1:0] rd_data,
   output logic             full,
   output logic             empty
);
   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [AW:0]      count;
   logic             do_wr;
   logic             do_rd;

   // A write into a full buffer is allowed when the head leaves in the same cycle
   assign do_wr   = wr_en && (!full || rd_en);
   assign do_rd   = rd_en && !empty;
   assign full    = (count == FULL_CNT);
   assign empty   = (count == '0);
   assign rd_data = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (do_wr) mem[wr_ptr] <= wr_data;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_wr) wr_ptr <= wr_ptr + 1'b1;
         if (do_rd) rd_ptr <= rd_ptr + 1'b1;
         count <= count + (AW+1)'(do_wr) - (AW+1)'(do_rd);
      end
   end

endmodule

// File: rtl/ccd_frame_sequencer.sv
// rtl/ccd_frame_sequencer.sv - arms on ccd_sp, captures one frame of ADC samples
// and streams it to the USB transmit path framed by header and checksum trailer
module ccd_frame_sequencer
   import ccd_seq_pkg::*;
#(
   parameter int         NUM_PIXELS = 5340,
   parameter int         DUMMY_LEAD = 32,
   parameter int         FIFO_DEPTH = 64,
   parameter logic [7:0] HDR0       = HDR0_DEF,
   parameter logic [7:0] HDR1       = HDR1_DEF
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        cmd_valid,
   input  logic [7:0]  cmd_data,
   output logic        cmd_ready,
   input  logic        ccd_sp,
   input  logic        pix_valid,
   input  logic [11:0] pix_data,
   input  logic        pix_of,
   output logic        tx_valid,
   output logic [7:0]  tx_data,
   input  logic        tx_ready,
   output logic        busy,
   output logic        overrun,
   output logic [7:0]  frame_cnt
);
   localparam int CW = $clog2(NUM_PIXELS + DUMMY_LEAD + 1);

   fe_state_t fe_state, fe_next;
   be_state_t be_state, be_next;

   logic [CW-1:0]       pix_cnt;
   logic [CW-1:0]       pay_left;
   logic                mode_cont;
   logic                stop_pending;
   logic                frame_ovr;
   logic [1:0]          be_idx, be_idx_next;
   logic                phase, phase_next;
   logic [7:0]          csum;
   logic                load, pay_byte, pop, sent;
   logic [7:0]          load_byte;
   logic                advance;
   logic                cmd_go, cmd_stop, frame_start, cap_pix, drop, be_done, skip_last;
   logic                fifo_full, fifo_empty;
   logic [SAMPLE_W-1:0] fifo_dout;

   assign cmd_ready   = ~rst;
   assign busy        = (fe_state != FE_IDLE);
   assign cmd_go      = cmd_valid && (fe_state == FE_IDLE) &&
                        ((cmd_data == CMD_SINGLE) || (cmd_data == CMD_CONT));
   assign cmd_stop    = cmd_valid && (fe_state != FE_IDLE) && (cmd_data == CMD_STOP);
   assign frame_start = (fe_state == FE_ARM) && ccd_sp;
   assign cap_pix     = (fe_state == FE_CAPTURE) && pix_valid;
   assign skip_last   = (pix_cnt == CW'(DUMMY_LEAD - 1));
   assign drop        = cap_pix && fifo_full && !pop;
   // Output register may take a new byte when empty or when its byte is being accepted
   assign advance     = !tx_valid || tx_ready;
   assign be_done     = (be_state == BE_TRL) && (be_idx == 2'd2) && tx_valid && tx_ready;

   sample_fifo #(
      .WIDTH (SAMPLE_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (cap_pix),
      .wr_data ({pix_of, pix_data}),
      .rd_en   (pop),
      .rd_data (fifo_dout),
      .full    (fifo_full),
      .empty   (fifo_empty)
   );

   always_comb begin
      fe_next = fe_state;
      case (fe_state)
         FE_IDLE:    if (cmd_go) fe_next = FE_ARM;
         FE_ARM:     if (ccd_sp) fe_next = FE_SKIP;
         FE_SKIP:    if (pix_valid && skip_last) fe_next = FE_CAPTURE;
         FE_CAPTURE: if (pix_valid && (pix_cnt == CW'(NUM_PIXELS - 1))) fe_next = FE_WAIT_TX;
         FE_WAIT_TX: if (be_done)
                        fe_next = (mode_cont && !stop_pending && !cmd_stop) ? FE_ARM : FE_IDLE;
         default:    fe_next = FE_IDLE;
      endcase
   end

   // Back end decides which byte, if any, enters the output register this cycle
   always_comb begin
      be_next     = be_state;
      be_idx_next = be_idx;
      phase_next  = phase;
      load        = 1'b0;
      load_byte   = 8'h00;
      pay_byte    = 1'b0;
      pop         = 1'b0;
      sent        = 1'b0;
      case (be_state)
         BE_IDLE: begin
            if (frame_start) begin
               load        = 1'b1;
               load_byte   = HDR0;
               be_next     = BE_HDR;
               be_idx_next = 2'd1;
            end
         end
         BE_HDR: begin
            if (advance) begin
               load = 1'b1;
               if (be_idx == 2'd1) begin
                  load_byte   = HDR1;
                  be_idx_next = 2'd2;
               end else begin
                  load_byte   = frame_cnt;
                  be_next     = BE_PAYLOAD;
                  be_idx_next = 2'd0;
                  phase_next  = 1'b0;
               end
            end
         end
         BE_PAYLOAD: begin
            if (advance) begin
               if (phase) begin
                  load       = 1'b1;
                  pay_byte   = 1'b1;
                  load_byte  = fifo_dout[7:0];
                  pop        = 1'b1;
                  sent       = 1'b1;
                  phase_next = 1'b0;
               end else if (pay_left == '0) begin
                  load        = 1'b1;
                  load_byte   = csum;
                  be_next     = BE_TRL;
                  be_idx_next = 2'd1;
               end else if (!fifo_empty) begin
                  load       = 1'b1;
                  pay_byte   = 1'b1;
                  load_byte  = {fifo_dout[12], 3'b000, fifo_dout[11:8]};
                  phase_next = 1'b1;
               end
            end
         end
         BE_TRL: begin
            if (advance) begin
               if (be_idx == 2'd1) begin
                  load        = 1'b1;
                  load_byte   = {7'b0, frame_ovr};
                  be_idx_next = 2'd2;
               end else begin
                  be_next     = BE_IDLE;
                  be_idx_next = 2'd0;
               end
            end
         end
         default: be_next = BE_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fe_state <= FE_IDLE;
         be_state <= BE_IDLE;
         be_idx   <= 2'd0;
         phase    <= 1'b0;
      end else begin
         fe_state <= fe_next;
         be_state <= be_next;
         be_idx   <= be_idx_next;
         phase    <= phase_next;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tx_valid     <= 1'b0;
         tx_data      <= 8'h00;
         pix_cnt      <= '0;
         pay_left     <= '0;
         csum         <= 8'h00;
         frame_ovr    <= 1'b0;
         overrun      <= 1'b0;
         mode_cont    <= 1'b0;
         stop_pending <= 1'b0;
         frame_cnt    <= 8'h00;
      end else begin
         if (advance) begin
            tx_valid <= load;
            if (load) tx_data <= load_byte;
         end
         if (frame_start) begin
            pix_cnt   <= '0;
            pay_left  <= CW'(NUM_PIXELS);
            csum      <= 8'h00;
            frame_ovr <= 1'b0;
         end else begin
            if ((fe_state == FE_SKIP) && pix_valid)
               pix_cnt <= skip_last ? '0 : pix_cnt + 1'b1;
            else if (cap_pix)
               pix_cnt <= pix_cnt + 1'b1;
            // Dropped samples shorten the payload just like transmitted ones
            pay_left <= pay_left - CW'(sent) - CW'(drop);
            if (load && pay_byte) csum <= csum + load_byte;
            if (drop) frame_ovr <= 1'b1;
         end
         if (cmd_go) begin
            mode_cont    <= (cmd_data == CMD_CONT);
            stop_pending <= 1'b0;
            overrun      <= 1'b0;
         end else begin
            if (cmd_stop) stop_pending <= 1'b1;
            if (drop) overrun <= 1'b1;
         end
         if (be_done) frame_cnt <= frame_cnt + 8'd1;
      end
   end

endmodule

// File: tb/tb_ccd_frame_sequencer.sv
// tb/tb_ccd_frame_sequencer.sv - directed self-checking bench for ccd_frame_sequencer
module tb_ccd_frame_sequencer;

   logic        clk;
   logic        rst;
   logic        cmd_valid;
   logic [7:0]  cmd_data;
   logic        cmd_ready;
   logic        ccd_sp;
   logic        pix_valid;
   logic [11:0] pix_data;
   logic        pix_of;
   logic        tx_valid;
   logic [7:0]  tx_data;
   logic        tx_ready;
   logic        busy;
   logic        overrun;
   logic [7:0]  frame_cnt;

   int          n_run    = 0;
   int          n_fail   = 0;
   int          unstable = 0;
   logic        rand_mode;
   logic        ready_fix;
   logic [7:0]  rxq [$];
   logic        prev_stall;
   logic [7:0]  prev_data;

   ccd_frame_sequencer #(
      .NUM_PIXELS (4),
      .DUMMY_LEAD (2),
      .FIFO_DEPTH (2)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .cmd_valid (cmd_valid),
      .cmd_data  (cmd_data),
      .cmd_ready (cmd_ready),
      .ccd_sp    (ccd_sp),
      .pix_valid (pix_valid),
      .pix_data  (pix_data),
      .pix_of    (pix_of),
      .tx_valid  (tx_valid),
      .tx_data   (tx_data),
      .tx_ready  (tx_ready),
      .busy      (busy),
      .overrun   (overrun),
      .frame_cnt (frame_cnt)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin : ready_drv
      int stall_run;
      stall_run = 0;
      tx_ready  = 1'b1;
      forever begin
         @(posedge clk);
         #2;
         if (rand_mode) begin
            if (stall_run >= 2 || ($urandom % 2) == 1) begin
               tx_ready  = 1'b1;
               stall_run = 0;
            end else begin
               tx_ready  = 1'b0;
               stall_run = stall_run + 1;
            end
         end else begin
            tx_ready = ready_fix;
         end
      end
   end

   always @(negedge clk) begin
      if (rst) begin
         prev_stall = 1'b0;
      end else begin
         if (prev_stall && (!tx_valid || tx_data !== prev_data)) unstable = unstable + 1;
         if (tx_valid && tx_ready) rxq.push_back(tx_data);
         prev_stall = tx_valid && !tx_ready;
         prev_data  = tx_data;
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_run = n_run + 1;
      if (got !== exp) begin
         n_fail = n_fail + 1;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_cmd(input logic [7:0] op);
      cmd_valid = 1'b1;
      cmd_data  = op;
      tick();
      cmd_valid = 1'b0;
   endtask

   task automatic pulse_sp();
      ccd_sp = 1'b1;
      tick();
      ccd_sp = 1'b0;
   endtask

   task automatic pix(input logic [11:0] d, input logic of, input int gap);
      pix_valid = 1'b1;
      pix_data  = d;
      pix_of    = of;
      tick();
      pix_valid = 1'b0;
      pix_of    = 1'b0;
      repeat (gap) tick();
   endtask

   task automatic run_pixels(input int of_idx, input int gap);
      for (int i = 1; i <= 6; i++) pix(12'(i), (i == of_idx), gap);
   endtask

   task automatic wait_idle(input string tag, input int budget);
      int n;
      n = 0;
      while (busy && n < budget) begin
         tick();
         n = n + 1;
      end
      check({tag, "_idle_timeout"}, busy, 0);
   endtask

   task automatic wait_cnt(input string tag, input logic [7:0] target, input int budget);
      int n;
      n = 0;
      while (frame_cnt != target && n < budget) begin
         tick();
         n = n + 1;
      end
      check({tag, "_cnt_timeout"}, frame_cnt, target);
   endtask

   task automatic check_frame(input string tag, input logic [7:0] exp [$]);
      int n;
      check({tag, "_len"}, rxq.size(), exp.size());
      n = (rxq.size() < exp.size()) ? rxq.size() : exp.size();
      for (int i = 0; i < n; i++) check($sformatf("%s_b%0d", tag, i), rxq[i], exp[i]);
      rxq.delete();
   endtask

   initial begin : main
      logic [7:0] e [$];
      rst       = 1'b1;
      cmd_valid = 1'b0;
      cmd_data  = 8'h00;
      ccd_sp    = 1'b0;
      pix_valid = 1'b0;
      pix_data  = 12'h000;
      pix_of    = 1'b0;
      rand_mode = 1'b0;
      ready_fix = 1'b1;
      repeat (3) tick();
      check("rst_tx_valid", tx_valid, 0);
      check("rst_busy", busy, 0);
      check("rst_overrun", overrun, 0);
      check("rst_frame_cnt", frame_cnt, 0);
      rst = 1'b0;
      tick();
      check("cmd_ready", cmd_ready, 1);

      // ccd_sp and stop in IDLE have no effect
      pulse_sp();
      tick();
      check("sp_idle_busy", busy, 0);
      check("sp_idle_tx_valid", tx_valid, 0);
      send_cmd(8'h03);
      check("stop_idle_busy", busy, 0);

      // Single frame; a pixel coinciding with the arming ccd_sp is not counted
      send_cmd(8'h01);
      check("arm_busy", busy, 1);
      check("arm_tx_valid", tx_valid, 0);
      ccd_sp    = 1'b1;
      pix_valid = 1'b1;
      pix_data  = 12'hFFF;
      tick();
      ccd_sp    = 1'b0;
      pix_valid = 1'b0;
      check("hdr_latency_valid", tx_valid, 1);
      check("hdr_latency_data", tx_data, 8'hA5);
      run_pixels(0, 2);
      wait_idle("f1", 200);
      e = '{8'hA5, 8'h5A, 8'h00, 8'h00, 8'h03, 8'h00, 8'h04, 8'h00, 8'h05, 8'h00, 8'h06, 8'h12, 8'h00};
      check_frame("f1", e);
      check("f1_frame_cnt", frame_cnt, 1);
      check("f1_overrun", overrun, 0);

      // Overflow flag on sample 5
      send_cmd(8'h01);
      pulse_sp();
      run_pixels(5, 2);
      wait_idle("f2", 200);
      e = '{8'hA5, 8'h5A, 8'h01, 8'h00, 8'h03, 8'h00, 8'h04, 8'h80, 8'h05, 8'h00, 8'h06, 8'h92, 8'h00};
      check_frame("f2", e);
      check("f2_frame_cnt", frame_cnt, 2);

      rst = 1'b1;
      tick();
      rst = 1'b0;
      tick();
      rxq.delete();
      check("rst2_frame_cnt", frame_cnt, 0);

      // Continuous mode, stop during the second frame
      send_cmd(8'h02);
      pulse_sp();
      run_pixels(0, 2);
      wait_cnt("c0", 8'd1, 200);
      tick();
      tick();
      check("cont_rearmed_busy", busy, 1);
      pulse_sp();
      pix(12'd1, 1'b0, 2);
      pix(12'd2, 1'b0, 2);
      send_cmd(8'h03);
      for (int i = 3; i <= 6; i++) pix(12'(i), 1'b0, 2);
      wait_idle("c1", 200);
      check("cont_frame_cnt", frame_cnt, 2);
      pulse_sp();
      run_pixels(0, 2);
      repeat (10) tick();
      check("cont_stopped_busy", busy, 0);
      e = '{8'hA5, 8'h5A, 8'h00, 8'h00, 8'h03, 8'h00, 8'h04, 8'h00, 8'h05, 8'h00, 8'h06, 8'h12, 8'h00,
            8'hA5, 8'h5A, 8'h01, 8'h00, 8'h03, 8'h00, 8'h04, 8'h00, 8'h05, 8'h00, 8'h06, 8'h12, 8'h00};
      check_frame("cont", e);

      // Transmit stalled through capture: two-entry buffer overflows
      ready_fix = 1'b0;
      send_cmd(8'h01);
      check("ovr_pre_overrun", overrun, 0);
      pulse_sp();
      run_pixels(0, 1);
      check("ovr_overrun", overrun, 1);
      ready_fix = 1'b1;
      wait_idle("ovr", 200);
      e = '{8'hA5, 8'h5A, 8'h02, 8'h00, 8'h03, 8'h00, 8'h04, 8'h07, 8'h01};
      check_frame("ovr", e);
      check("ovr_frame_cnt", frame_cnt, 3);
      check("ovr_sticky", overrun, 1);

      // Random back-pressure
      send_cmd(8'h01);
      check("rand_overrun_cleared", overrun, 0);
      rand_mode = 1'b1;
      pulse_sp();
      run_pixels(0, 9);
      wait_idle("rand", 400);
      rand_mode = 1'b0;
      tick();
      e = '{8'hA5, 8'h5A, 8'h03, 8'h00, 8'h03, 8'h00, 8'h04, 8'h00, 8'h05, 8'h00, 8'h06, 8'h12, 8'h00};
      check_frame("rand", e);
      check("rand_stable", unstable, 0);
      check("rand_frame_cnt", frame_cnt, 4);

      // Asynchronous reset in the middle of the payload
      send_cmd(8'h01);
      pulse_sp();
      for (int i = 1; i <= 4; i++) pix(12'(i), 1'b0, 0);
      @(negedge clk);
      check("mid_pre_tx_valid", tx_valid, 1);
      #1 rst = 1'b1;
      #1;
      check("mid_rst_tx_valid", tx_valid, 0);
      check("mid_rst_busy", busy, 0);
      check("mid_rst_frame_cnt", frame_cnt, 0);
      tick();
      rst = 1'b0;
      tick();
      rxq.delete();
      send_cmd(8'h01);
      pulse_sp();
      run_pixels(0, 2);
      wait_idle("post", 200);
      e = '{8'hA5, 8'h5A, 8'h00, 8'h00, 8'h03, 8'h00, 8'h04, 8'h00, 8'h05, 8'h00, 8'h06, 8'h12, 8'h00};
      check_frame("post", e);
      check("post_frame_cnt", frame_cnt, 1);

      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule
